// File: rtl/fifo_serial_tx.sv
// fifo_serial_tx: drains words from a FIFO read port and sends each one as a
// serial frame: start bit (0), `width` data bits LSB first, stop bit (1).
// Each bit lasts clks_per_bit clocks. All outputs are decoded from registers.
module fifo_serial_tx #(
  parameter int width        = 4,
  parameter int clks_per_bit = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             empty,
  input  logic [width-1:0] rd_data,
  output logic             pop,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);

  localparam int baud_w = (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  localparam int bit_w  = (width > 1) ? $clog2(width) : 1;
  localparam logic [baud_w-1:0] baud_last = baud_w'(clks_per_bit - 1);
  localparam logic [bit_w-1:0]  bit_last  = bit_w'(width - 1);

  typedef enum logic [2:0] {IDLE, POP, FETCH, START, DATA, STOP} state_t;

  state_t             state_reg, state_next;
  logic [baud_w-1:0]  baud_reg, baud_next;
  logic [bit_w-1:0]   bit_reg, bit_next;
  logic [width-1:0]   shift_reg, shift_next;
  logic               baud_tick;

  // A bit period ends when the baud counter reaches its last value.
  assign baud_tick = (baud_reg == baud_last);

  // State and counter registers; reset drops any frame in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
    end
  end

  // Next-state logic: sequences pop, fetch, then the start/data/stop bits.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    case (state_reg)
      IDLE: begin
        if (en && !empty) state_next = POP;
      end
      POP: begin
        state_next = FETCH;
      end
      FETCH: begin
        // The FIFO head word is valid on rd_data in the cycle after pop.
        shift_next = rd_data;
        baud_next  = '0;
        state_next = START;
      end
      START: begin
        if (baud_tick) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end else begin
          baud_next = baud_reg + baud_w'(1);
        end
      end
      DATA: begin
        if (baud_tick) begin
          baud_next  = '0;
          shift_next = shift_reg >> 1;
          if (bit_reg == bit_last) begin
            bit_next   = '0;
            state_next = STOP;
          end else begin
            bit_next = bit_reg + bit_w'(1);
          end
        end else begin
          baud_next = baud_reg + baud_w'(1);
        end
      end
      STOP: begin
        if (baud_tick) begin
          baud_next = '0;
          // Chain straight into the next pop so frames run back to back.
          if (en && !empty) state_next = POP;
          else              state_next = IDLE;
        end else begin
          baud_next = baud_reg + baud_w'(1);
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
        bit_next   = '0;
      end
    endcase
  end

  // Moore output decode from the registered state and counters.
  always_comb begin
    pop        = (state_reg == POP);
    busy       = (state_reg != IDLE);
    frame_done = (state_reg == STOP) && baud_tick;
    case (state_reg)
      START:   tx = 1'b0;
      DATA:    tx = shift_reg[0];
      default: tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: a FIFO model feeds the DUT, stimulus pushes the
// expected words into a scoreboard, and a monitor decodes every tx frame.
module tb_fifo_serial_tx;

  localparam int W  = 4;
  localparam int C  = 4;
  localparam int FL = (W + 2) * C;

  logic         clk = 1'b0;
  logic         rstn = 1'b1;
  logic         en = 1'b0;
  logic         empty;
  logic [W-1:0] rd_data = 4'h5;
  logic         pop, tx, busy, frame_done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [W-1:0] mem [0:63];
  int           wr_cnt = 0;
  int           rd_cnt = 0;

  logic [W-1:0] expq [$];
  int           popq [$];
  int           fdq  [$];

  always #5 clk = ~clk;

  fifo_serial_tx #(.width(W), .clks_per_bit(C)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .empty      (empty),
    .rd_data    (rd_data),
    .pop        (pop),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // FIFO model: head word appears on rd_data the cycle after pop.
  assign empty = (wr_cnt == rd_cnt);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pop) begin
      rd_data <= mem[rd_cnt[5:0]];
      rd_cnt  <= rd_cnt + 1;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    mem[wr_cnt[5:0]] = w;
    wr_cnt++;
    expq.push_back(w);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Log pop pulses and frame_done pulses with their cycle numbers.
  always @(negedge clk) begin
    if (pop) begin
      popq.push_back(cyc);
      $display("pop at cycle %0d", cyc);
      check("pop_nonempty", int'(empty), 0);
    end
    if (frame_done) fdq.push_back(cyc);
  end

  // Monitor: on a start bit, check every cycle of the frame against the
  // next expected word and compare the decoded word.
  initial begin
    logic [W-1:0] ew, aw;
    logic         eb;
    int           errs, fde, b;
    bit           ab;
    forever begin
      @(negedge clk);
      if (rstn === 1'b1 && tx === 1'b0) begin
        if (expq.size() == 0) begin
          check("unexpected_frame", 1, 0);
          repeat (FL - 1) @(negedge clk);
        end else begin
          ew = expq.pop_front();
          aw = '0; errs = 0; fde = 0; ab = 0;
          for (int j = 0; j < FL; j++) begin
            if (j > 0) @(negedge clk);
            if (!rstn) begin
              ab = 1;
              break;
            end
            b = j / C;
            if (b == 0)      eb = 1'b0;
            else if (b <= W) eb = ew[b-1];
            else             eb = 1'b1;
            if (tx !== eb || busy !== 1'b1) errs++;
            if (b >= 1 && b <= W && (j % C) == 0) aw[b-1] = tx;
            if (frame_done !== (j == FL - 1)) fde++;
          end
          if (ab) begin
            $display("frame expected=%0h aborted by reset", ew);
          end else begin
            $display("frame got=%0h expected=%0h bit_errs=%0d", aw, ew, errs);
            check("frame_word", int'(aw), int'(ew));
            check("frame_bit_errs", errs, 0);
            check("frame_done_pos", fde, 0);
          end
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    int c0, c1, viol;

    // Reset behaviour.
    #1 rstn = 1'b0;
    #2 check("reset_outs_t3", int'({tx, pop, busy, frame_done}), 4'b1000);
    #9 check("reset_outs_t12", int'({tx, pop, busy, frame_done}), 4'b1000);
    #5 rstn = 1'b1;
    @(negedge clk);

    // Single word 1010.
    push(4'b1010);
    c0 = cyc;
    en = 1'b1;
    wait_cycles(40);
    check("t2_pop_count", popq.size(), 1);
    check("t2_pop_cycle", popq[0], c0 + 1);
    check("t2_fd_count", fdq.size(), 1);
    check("t2_fd_latency", fdq[0] - popq[0], 25);
    check("t2_busy_after", int'(busy), 0);
    check("t2_tx_after", int'(tx), 1);
    popq.delete(); fdq.delete();

    // Back to back 0..4.
    en = 1'b0;
    for (int i = 0; i < 5; i++) push(W'(i));
    wait_cycles(1);
    c0 = cyc;
    en = 1'b1;
    wait_cycles(5 * 26 + 20);
    check("t3_pop_count", popq.size(), 5);
    check("t3_first_pop", popq[0], c0 + 1);
    for (int i = 1; i < 5; i++) check("t3_pop_spacing", popq[i] - popq[i-1], 26);
    check("t3_fd_count", fdq.size(), 5);
    popq.delete(); fdq.delete();

    // Empty FIFO with en high.
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0 || pop !== 1'b0) viol++;
    end
    check("t4_idle_viol", viol, 0);
    check("t4_pop_count", popq.size(), 0);

    // Enable dropped during frame 1 data.
    en = 1'b0;
    push(4'h5); push(4'hA); push(4'hC);
    wait_cycles(1);
    c0 = cyc;
    en = 1'b1;
    wait_cycles(11);
    en = 1'b0;
    wait_cycles(40);
    check("t5_pop_count_en0", popq.size(), 1);
    check("t5_fd_count_en0", fdq.size(), 1);
    check("t5_fd_cycle", fdq[0], c0 + 26);
    c1 = cyc;
    en = 1'b1;
    wait_cycles(2 * 26 + 10);
    check("t5_pop_count", popq.size(), 3);
    check("t5_resume_pop", popq[1], c1 + 1);
    check("t5_pop_spacing", popq[2] - popq[1], 26);
    check("t5_fd_count", fdq.size(), 3);
    popq.delete(); fdq.delete();

    // Reset during data bit 2.
    push(4'h9);
    c0 = cyc;
    wait_cycles(15);
    check("t6_busy_before", int'(busy), 1);
    #2 rstn = 1'b0;
    #1 check("t6_async_tx", int'(tx), 1);
    check("t6_async_busy", int'(busy), 0);
    @(negedge clk);
    @(posedge clk);
    #2 rstn = 1'b1;
    popq.delete(); fdq.delete();
    push(4'h6);
    wait_cycles(40);
    check("t6_pop_count", popq.size(), 1);
    check("t6_fd_count", fdq.size(), 1);

    wait_cycles(5);
    check("exp_queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
